// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs req/ack fetches and holds one instruction for IF/ID.
// Optional feature macro: IF_MISALIGN_CHK_EN (adds misalign_o and word-aligns redirect targets).
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_INC   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pc_write_i,
    input  logic        ifid_write_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        valid_o,
    output logic [31:0] address_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_add4_o
`ifdef IF_MISALIGN_CHK_EN
    ,
    output logic        misalign_o
`endif
);

    localparam logic [31:0] PC_STEP = 32'(PC_INC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] target_s;
    logic [31:0] next_seq_s;

    // Redirect target selection and sequential-PC arithmetic
`ifdef IF_MISALIGN_CHK_EN
    logic misalign_s;

    always_comb begin
        target_s   = {redirect_addr_i[31:2], 2'b00};
        misalign_s = redirect_i && (redirect_addr_i[1:0] != 2'b00);
        next_seq_s = imem_addr_o + PC_STEP;
    end
`else
    always_comb begin
        target_s   = redirect_addr_i;
        next_seq_s = imem_addr_o + PC_STEP;
    end
`endif

    // Fetch FSM with all outputs registered; redirect has priority in every state
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= IDLE;
            pc_r        <= RESET_PC;
            imem_req_o  <= 1'b0;
            imem_addr_o <= 32'h0000_0000;
            valid_o     <= 1'b0;
            address_o   <= 32'h0000_0000;
            instr_o     <= 32'h0000_0000;
            pc_add4_o   <= 32'h0000_0000;
`ifdef IF_MISALIGN_CHK_EN
            misalign_o  <= 1'b0;
`endif
        end else begin
`ifdef IF_MISALIGN_CHK_EN
            misalign_o <= misalign_s;
`endif
            case (state_r)
                IDLE: begin
                    if (redirect_i) begin
                        pc_r    <= target_s;
                        valid_o <= 1'b0;
                    end else if (pc_write_i) begin
                        imem_req_o  <= 1'b1;
                        imem_addr_o <= pc_r;
                        state_r     <= FETCH;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FETCH: begin
                    if (redirect_i) begin
                        pc_r    <= target_s;
                        valid_o <= 1'b0;
                        // A request already accepted by memory must complete before refetching
                        if (imem_ack_i) begin
                            imem_req_o <= 1'b0;
                            state_r    <= IDLE;
                        end else begin
                            state_r <= DRAIN;
                        end
                    end else if (imem_ack_i) begin
                        imem_req_o <= 1'b0;
                        instr_o    <= imem_data_i;
                        address_o  <= imem_addr_o;
                        pc_add4_o  <= next_seq_s;
                        pc_r       <= next_seq_s;
                        valid_o    <= 1'b1;
                        state_r    <= HOLD;
                    end else begin
                        state_r <= FETCH;
                    end
                end
                HOLD: begin
                    if (redirect_i) begin
                        pc_r    <= target_s;
                        valid_o <= 1'b0;
                        state_r <= IDLE;
                    end else if (ifid_write_i && pc_write_i) begin
                        valid_o     <= 1'b0;
                        imem_req_o  <= 1'b1;
                        imem_addr_o <= pc_r;
                        state_r     <= FETCH;
                    end else if (ifid_write_i) begin
                        valid_o <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                DRAIN: begin
                    if (redirect_i) begin
                        pc_r <= target_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                    if (imem_ack_i) begin
                        imem_req_o <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    imem_req_o <= 1'b0;
                    valid_o    <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: sequential fetch, stall, redirects, wrap, async reset.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        pc_write;
    logic        ifid_write;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        valid;
    logic [31:0] address;
    logic [31:0] instr;
    logic [31:0] pc_add4;
`ifdef IF_MISALIGN_CHK_EN
    logic        misalign;
`endif

    int tests  = 0;
    int failed = 0;

    if_fetch_stage dut (
`ifdef IF_MISALIGN_CHK_EN
        .misalign_o      (misalign),
`endif
        .clk_i           (clk),
        .rst_i           (rst_i),
        .pc_write_i      (pc_write),
        .ifid_write_i    (ifid_write),
        .redirect_i      (redirect),
        .redirect_addr_i (redirect_addr),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_ack_i      (imem_ack),
        .imem_data_i     (imem_data),
        .valid_o         (valid),
        .address_o       (address),
        .instr_o         (instr),
        .pc_add4_o       (pc_add4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_fetch(input string tag, input logic [31:0] addr);
        check1({tag, ".req"}, imem_req, 1'b1);
        check32({tag, ".addr"}, imem_addr, addr);
        check1({tag, ".valid"}, valid, 1'b0);
    endtask

    task automatic expect_hold(input string tag, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] a4);
        check1({tag, ".valid"}, valid, 1'b1);
        check1({tag, ".req"}, imem_req, 1'b0);
        check32({tag, ".address"}, address, a);
        check32({tag, ".instr"}, instr, d);
        check32({tag, ".pc_add4"}, pc_add4, a4);
    endtask

    task automatic expect_quiet(input string tag);
        check1({tag, ".req"}, imem_req, 1'b0);
        check1({tag, ".valid"}, valid, 1'b0);
    endtask

    task automatic expect_all_zero(input string tag);
        check1({tag, ".req"}, imem_req, 1'b0);
        check32({tag, ".addr"}, imem_addr, 32'h0000_0000);
        check1({tag, ".valid"}, valid, 1'b0);
        check32({tag, ".address"}, address, 32'h0000_0000);
        check32({tag, ".instr"}, instr, 32'h0000_0000);
        check32({tag, ".pc_add4"}, pc_add4, 32'h0000_0000);
    endtask

    initial begin
        rst_i         = 1'b0;
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        redirect      = 1'b0;
        redirect_addr = 32'h0000_0000;
        imem_ack      = 1'b0;
        imem_data     = 32'h0000_0000;
        tick();
        tick();
        expect_all_zero("reset");

        // Sequential fetch 0, 4, 8
        rst_i = 1'b1;
        tick();
        expect_fetch("seq0_req", 32'h0000_0000);
        imem_ack = 1'b1; imem_data = 32'h0000_0013;
        tick();
        expect_hold("seq0", 32'h0000_0000, 32'h0000_0013, 32'h0000_0004);
        imem_ack = 1'b0;
        tick();
        expect_fetch("seq1_req", 32'h0000_0004);
        imem_ack = 1'b1; imem_data = 32'hA1A1_0001;
        tick();
        expect_hold("seq1", 32'h0000_0004, 32'hA1A1_0001, 32'h0000_0008);
        imem_ack = 1'b0;
        tick();
        expect_fetch("seq2_req", 32'h0000_0008);
        imem_ack = 1'b1; imem_data = 32'hA2A2_0002;
        tick();
        expect_hold("seq2", 32'h0000_0008, 32'hA2A2_0002, 32'h0000_000C);

        // IF/ID stalled for 5 cycles; a stray ack while idle on the bus is ignored
        imem_ack = 1'b0; ifid_write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            imem_ack  = (i == 2);
            imem_data = 32'hDEAD_BEEF;
            tick();
            expect_hold("stall", 32'h0000_0008, 32'hA2A2_0002, 32'h0000_000C);
        end
        imem_ack = 1'b0; ifid_write = 1'b1;
        tick();
        expect_fetch("after_stall_req", 32'h0000_000C);

        // Redirect during FETCH with ack delayed: request drains on old address
        redirect = 1'b1; redirect_addr = 32'h0000_0100;
        tick();
        expect_fetch("drain0", 32'h0000_000C);
        redirect = 1'b0;
        tick();
        expect_fetch("drain1", 32'h0000_000C);
        tick();
        expect_fetch("drain2", 32'h0000_000C);
        imem_ack = 1'b1; imem_data = 32'hBAD0_BAD0;
        tick();
        expect_quiet("drain_ack");
        imem_ack = 1'b0;
        tick();
        expect_fetch("redir_req", 32'h0000_0100);

        // Redirect coincident with ack and ifid_write: instruction dropped
        imem_ack = 1'b1; imem_data = 32'hBAD1_BAD1;
        redirect = 1'b1; redirect_addr = 32'h0000_0200;
        tick();
        expect_quiet("redir_ack");
        imem_ack = 1'b0; redirect = 1'b0;
        tick();
        expect_fetch("redir_ack_req", 32'h0000_0200);
        imem_ack = 1'b1; imem_data = 32'hB1B1_0001;
        tick();
        expect_hold("tgt", 32'h0000_0200, 32'hB1B1_0001, 32'h0000_0204);

        // Redirect wins over ifid_write while holding
        imem_ack = 1'b0; redirect = 1'b1; redirect_addr = 32'h0000_0300;
        tick();
        expect_quiet("redir_hold");
        redirect = 1'b0;
        tick();
        expect_fetch("redir_hold_req", 32'h0000_0300);

        // Hazard stall: consumed instruction with pc_write low parks in IDLE
        imem_ack = 1'b1; imem_data = 32'hC0C0_0000; pc_write = 1'b0;
        tick();
        expect_hold("pcw0", 32'h0000_0300, 32'hC0C0_0000, 32'h0000_0304);
        imem_ack = 1'b0;
        tick();
        expect_quiet("pcw0_idle0");
        tick();
        expect_quiet("pcw0_idle1");
        pc_write = 1'b1;
        tick();
        expect_fetch("pcw1_req", 32'h0000_0304);

        // PC wrap at the top of the address space
        redirect = 1'b1; redirect_addr = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0; imem_ack = 1'b1;
        tick();
        expect_quiet("wrap_drain");
        imem_ack = 1'b0;
        tick();
        expect_fetch("wrap_req", 32'hFFFF_FFFC);
        imem_ack = 1'b1; imem_data = 32'hD0D0_0000;
        tick();
        expect_hold("wrap", 32'hFFFF_FFFC, 32'hD0D0_0000, 32'h0000_0000);
        imem_ack = 1'b0;
        tick();
        expect_fetch("wrap_next_req", 32'h0000_0000);

        // Misaligned redirect target
        redirect = 1'b1; redirect_addr = 32'h0000_0102;
        tick();
`ifdef IF_MISALIGN_CHK_EN
        check1("misalign_hi", misalign, 1'b1);
`endif
        redirect = 1'b0; imem_ack = 1'b1;
        tick();
`ifdef IF_MISALIGN_CHK_EN
        check1("misalign_lo", misalign, 1'b0);
`endif
        expect_quiet("mis_drain");
        imem_ack = 1'b0;
        tick();
`ifdef IF_MISALIGN_CHK_EN
        expect_fetch("mis_req", 32'h0000_0100);
`else
        expect_fetch("mis_req", 32'h0000_0102);
`endif

        // Asynchronous reset mid-FETCH
        #3;
        rst_i = 1'b0;
        #1;
        expect_all_zero("async_rst");
        tick();
        rst_i = 1'b1;
        tick();
        expect_fetch("post_rst_req", 32'h0000_0000);
        imem_ack = 1'b1; imem_data = 32'hE0E0_0000;
        tick();
        expect_hold("post_rst", 32'h0000_0000, 32'hE0E0_0000, 32'h0000_0004);
        imem_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
